// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: ALU op codes, FSM state
// encodings and small op-decoding helpers.
package div_sequencer_pkg;

   // ALU op encodings used by the EX stage
   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_AND    = 5'd2;
   localparam logic [4:0] ALU_OR     = 5'd3;
   localparam logic [4:0] ALU_XOR    = 5'd4;
   localparam logic [4:0] ALU_SLL    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_SLT    = 5'd8;
   localparam logic [4:0] ALU_SLTU   = 5'd9;
   localparam logic [4:0] ALU_MUL    = 5'd10;
   localparam logic [4:0] ALU_MULH   = 5'd11;
   localparam logic [4:0] ALU_MULHSU = 5'd12;
   localparam logic [4:0] ALU_MULHU  = 5'd13;
   localparam logic [4:0] ALU_DIV    = 5'd14;
   localparam logic [4:0] ALU_DIVU   = 5'd15;
   localparam logic [4:0] ALU_REM    = 5'd16;
   localparam logic [4:0] ALU_REMU   = 5'd17;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // True for the four ops this sequencer executes
   function automatic logic is_div_op(input logic [4:0] op);
      return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
   endfunction

   // True for the signed variants (DIV, REM)
   function automatic logic is_signed_op(input logic [4:0] op);
      return (op == ALU_DIV) || (op == ALU_REM);
   endfunction

   // True when the remainder, not the quotient, is the result
   function automatic logic is_rem_op(input logic [4:0] op);
      return (op == ALU_REM) || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the EX stage and the divide sequencer.
interface div_sequencer_if #(parameter int N = 32);
   logic         start;
   logic [4:0]   alu_control;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         flush;
   logic         busy;
   logic         stall;
   logic         done;
   logic [N-1:0] result;

   // Pipeline side issues requests and consumes results
   modport master (
      output start, alu_control, a, b, flush,
      input  busy, stall, done, result
   );

   // Sequencer side
   modport slave (
      input  start, alu_control, a, b, flush,
      output busy, stall, done, result
   );
endinterface

// File: rtl/div_sequencer_step.sv
// One combinational radix-2 restoring division iteration.
module div_step #(
   parameter int N = 32
) (
   input  logic [N-1:0] rem,
   input  logic [N-1:0] quo,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] rem_next,
   output logic [N-1:0] quo_next
);

   logic [N:0] rem_sh;
   logic [N:0] trial;

   // Shift {rem,quo} left by one; the partial remainder is always below the
   // divisor, so N+1 bits are enough for the trial subtraction and its sign.
   assign rem_sh   = {rem, quo[N-1]};
   assign trial    = rem_sh - {1'b0, divisor};
   assign rem_next = trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
   assign quo_next = {quo[N-2:0], ~trial[N]};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer. Runs N restoring steps on the
// operand magnitudes, fixes up signs, and stalls the pipeline meanwhile.
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int N = 32
) (
   input  logic          clk,
   input  logic          rst,
   div_sequencer_if.slave bus
);

   localparam int CW = $clog2(N);
   localparam logic [N-1:0] MIN_NEG  = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
   localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

   div_state_e   state_reg;
   logic [4:0]   op_reg;
   logic         neg_q_reg;
   logic         neg_r_reg;
   logic [N-1:0] quo_reg;
   logic [N-1:0] rem_reg;
   logic [N-1:0] dvs_reg;
   logic [CW-1:0] count_reg;
   logic         busy_reg;
   logic         done_reg;
   logic [N-1:0] result_reg;

   logic         op_signed;
   logic         a_neg;
   logic         b_neg;
   logic [N-1:0] a_mag;
   logic [N-1:0] b_mag;
   logic         div_zero;
   logic         overflow;
   logic         accept;
   logic [N-1:0] special_result;
   logic [N-1:0] fixed_quo;
   logic [N-1:0] fixed_rem;
   logic [N-1:0] fix_result;
   logic [N-1:0] step_rem;
   logic [N-1:0] step_quo;

   // Two's complement negation
   function automatic logic [N-1:0] negate(input logic [N-1:0] x);
      return ~x + ONE;
   endfunction

   // Request decode: magnitudes, special cases and the accept condition
   always_comb begin
      op_signed = is_signed_op(bus.alu_control);
      a_neg     = op_signed & bus.a[N-1];
      b_neg     = op_signed & bus.b[N-1];
      a_mag     = a_neg ? negate(bus.a) : bus.a;
      b_mag     = b_neg ? negate(bus.b) : bus.b;
      div_zero  = (bus.b == '0);
      overflow  = op_signed && (bus.a == MIN_NEG) && (bus.b == ALL_ONES);
      accept    = (state_reg == DIV_IDLE) && bus.start && is_div_op(bus.alu_control) && !bus.flush;
      if (div_zero)
         special_result = is_rem_op(bus.alu_control) ? bus.a : ALL_ONES;
      else
         special_result = is_rem_op(bus.alu_control) ? '0 : MIN_NEG;
   end

   // Sign fix-up and quotient/remainder selection for the FIX state
   always_comb begin
      fixed_quo  = neg_q_reg ? negate(quo_reg) : quo_reg;
      fixed_rem  = neg_r_reg ? negate(rem_reg) : rem_reg;
      fix_result = is_rem_op(op_reg) ? fixed_rem : fixed_quo;
   end

   div_step #(.N(N)) u_step (
      .rem      (rem_reg),
      .quo      (quo_reg),
      .divisor  (dvs_reg),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   // Sequencer FSM with registered busy/done/result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= DIV_IDLE;
         op_reg     <= ALU_ADD;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         quo_reg    <= '0;
         rem_reg    <= '0;
         dvs_reg    <= '0;
         count_reg  <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         result_reg <= '0;
      end else if (bus.flush) begin
         // Abort: result keeps its last completed value
         state_reg <= DIV_IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            DIV_IDLE: begin
               done_reg <= 1'b0;
               if (accept) begin
                  op_reg    <= bus.alu_control;
                  neg_q_reg <= a_neg ^ b_neg;
                  neg_r_reg <= a_neg;
                  quo_reg   <= a_mag;
                  rem_reg   <= '0;
                  dvs_reg   <= b_mag;
                  count_reg <= CW'(N-1);
                  busy_reg  <= 1'b1;
                  if (div_zero || overflow) begin
                     result_reg <= special_result;
                     done_reg   <= 1'b1;
                     state_reg  <= DIV_DONE;
                  end else begin
                     state_reg <= DIV_CALC;
                  end
               end else begin
                  busy_reg <= 1'b0;
               end
            end
            DIV_CALC: begin
               quo_reg <= step_quo;
               rem_reg <= step_rem;
               if (count_reg == '0)
                  state_reg <= DIV_FIX;
               else
                  count_reg <= count_reg - CW'(1);
            end
            DIV_FIX: begin
               result_reg <= fix_result;
               done_reg   <= 1'b1;
               state_reg  <= DIV_DONE;
            end
            DIV_DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= DIV_IDLE;
            end
            default: begin
               state_reg <= DIV_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Stall covers the accept cycle and every cycle until DONE
   assign bus.stall  = accept || (state_reg == DIV_CALC) || (state_reg == DIV_FIX);
   assign bus.busy   = busy_reg;
   assign bus.done   = done_reg;
   assign bus.result = result_reg;

endmodule
